// File: rtl/cpu_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_pkg
// Purpose  : Shared constants for the CPU step/clock controller: push-switch
//            channel roles, run/stop mode encoding and the rate-select width.
// Revision : 1.0  initial release
// ============================================================================
package cpu_step_pkg;

  // Push-switch channel roles
  localparam int SW_STEP = 0;
  localparam int SW_RUN  = 1;
  localparam int SW_RATE = 2;
  localparam int SW_CLR  = 3;

  // Width of the run-rate select
  localparam int RATE_W = 2;

  // CPU clocking mode
  typedef enum logic {
    MODE_STOP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/cpu_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_ctrl_if
// Purpose  : Bundle of switch inputs and CPU-clock/status outputs between the
//            board-level switch logic and the controller.
//   PSW       raw push switches            (master -> slave)
//   PSW_SIG   debounced levels             (slave  -> master)
//   PSW_PULSE debounced rising-edge pulses (slave  -> master)
//   CPU_EN    one-cycle CPU step request   (slave  -> master)
//   CPU_CLK   stretched CPU clock          (slave  -> master)
//   MODE      0 = stop/single-step, 1 = run
//   RATE      run-rate select
//   STEP_CNT  issued CPU clock count
//   BRK_CNT   breakpoint count, only with CPU_STEP_BREAK_EN defined
// Config   : `CPU_STEP_BREAK_EN adds the BRK_CNT signal.
// Revision : 1.0  initial release
// ============================================================================
interface cpu_step_ctrl_if
  import cpu_step_pkg::*;
#(
  parameter int NSW   = 4,
  parameter int CNT_W = 16
);
  logic [NSW-1:0]    PSW;
  logic [NSW-1:0]    PSW_SIG;
  logic [NSW-1:0]    PSW_PULSE;
  logic              CPU_EN;
  logic              CPU_CLK;
  logic              MODE;
  logic [RATE_W-1:0] RATE;
  logic [CNT_W-1:0]  STEP_CNT;
`ifdef CPU_STEP_BREAK_EN
  logic [CNT_W-1:0]  BRK_CNT;

  modport slave  (input  PSW, BRK_CNT,
                  output PSW_SIG, PSW_PULSE, CPU_EN, CPU_CLK, MODE, RATE, STEP_CNT);
  modport master (output PSW, BRK_CNT,
                  input  PSW_SIG, PSW_PULSE, CPU_EN, CPU_CLK, MODE, RATE, STEP_CNT);
`else
  modport slave  (input  PSW,
                  output PSW_SIG, PSW_PULSE, CPU_EN, CPU_CLK, MODE, RATE, STEP_CNT);
  modport master (output PSW,
                  input  PSW_SIG, PSW_PULSE, CPU_EN, CPU_CLK, MODE, RATE, STEP_CNT);
`endif
endinterface
`default_nettype wire

// File: rtl/cpu_step_ctrl_psw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : psw_debounce
// Purpose  : One push-switch channel: two-flop synchroniser, stability counter,
//            debounced level and one-cycle rising-edge pulse.
//   clk_i    board clock
//   rst_ni   asynchronous active-low reset
//   psw_i    raw switch, asynchronous to clk_i
//   sig_o    debounced level
//   pulse_o  one-cycle pulse in the cycle sig_o rises
// Revision : 1.0  initial release
// ============================================================================
module psw_debounce #(
  parameter int DB_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic psw_i,
  output logic sig_o,
  output logic pulse_o
);
  localparam int CW = $clog2(DB_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          sig_q, pulse_q;
  logic [CW-1:0] cnt_q;
  logic          done;

  // The DB_CYC-th consecutive differing sample is the one that flips the level.
  assign done = (cnt_q == CW'(DB_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sig_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= psw_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q != sig_q) begin
        if (done) begin
          sig_q   <= sync2_q;
          pulse_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign sig_o   = sig_q;
  assign pulse_o = pulse_q;
endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_ctrl
// Purpose  : Board-level CPU clock controller. Debounces NSW push switches and
//            generates single-step or free-running (4 rates) CPU clocks with a
//            step counter for the display.
//   CLK   board clock, rising edge
//   RSTN  asynchronous active-low reset
//   bus   cpu_step_ctrl_if.slave: PSW in; PSW_SIG, PSW_PULSE, CPU_EN,
//         CPU_CLK, MODE, RATE, STEP_CNT out; BRK_CNT in (breakpoint build)
// Config   : `CPU_STEP_BREAK_EN enables the STEP_CNT == BRK_CNT run breakpoint.
// Revision : 1.0  initial release
// ============================================================================
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int NSW     = 4,
  parameter int DB_CYC  = 50000,
  parameter int DIV_W   = 24,
  parameter int STRETCH = 4,
  parameter int CNT_W   = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  cpu_step_ctrl_if.slave bus
);
  localparam int STR_W = $clog2(STRETCH + 1);

  logic [NSW-1:0]    sig, pulse;
  mode_e             mode_q, mode_d;
  logic [RATE_W-1:0] rate_q;
  logic [DIV_W-1:0]  div_q, run_mask;
  logic              tick_q, cpu_en_q, cpu_en_d;
  logic [STR_W-1:0]  stretch_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic              brk_hit;

  for (genvar i = 0; i < NSW; i++) begin : g_db
    psw_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk_i  (CLK),
      .rst_ni (RSTN),
      .psw_i  (bus.PSW[i]),
      .sig_o  (sig[i]),
      .pulse_o(pulse[i])
    );
  end

  // Each rate step halves the tick period twice: mask keeps DIV_W-2*RATE bits.
  assign run_mask = {DIV_W{1'b1}} >> {rate_q, 1'b0};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // A request is dropped unless the previous CPU clock has fully finished.
  assign cpu_en_d = ((pulse[SW_STEP] && (mode_q == MODE_STOP)) ||
                     (tick_q && (mode_q == MODE_RUN))) && (stretch_q == '0);

  always_comb begin
    brk_hit = 1'b0;
`ifdef CPU_STEP_BREAK_EN
    brk_hit = cpu_en_q && (mode_q == MODE_RUN) &&
              (bus.BRK_CNT != '0) && (cnt_inc == bus.BRK_CNT);
`endif
    mode_d = mode_q;
    case (mode_q)
      MODE_STOP: if (pulse[SW_RUN]) mode_d = MODE_RUN;
      MODE_RUN:  if (brk_hit || pulse[SW_RUN]) mode_d = MODE_STOP;
      default:   mode_d = MODE_STOP;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) mode_q <= MODE_STOP;
    else       mode_q <= mode_d;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rate_q    <= '0;
      div_q     <= '0;
      tick_q    <= 1'b0;
      cpu_en_q  <= 1'b0;
      stretch_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (pulse[SW_RATE]) rate_q <= rate_q + RATE_W'(1);

      if ((mode_q == MODE_STOP) && pulse[SW_RUN]) div_q <= '0;
      else if (mode_q == MODE_RUN)                div_q <= div_q + DIV_W'(1);

      tick_q   <= (mode_q == MODE_RUN) && ((div_q & run_mask) == run_mask);
      cpu_en_q <= cpu_en_d;

      // CPU_CLK starts the cycle after CPU_EN, so the load keys off cpu_en_q.
      if (cpu_en_q)               stretch_q <= STR_W'(STRETCH);
      else if (stretch_q != '0)   stretch_q <= stretch_q - STR_W'(1);

      if (pulse[SW_CLR])  cnt_q <= '0;
      else if (cpu_en_q)  cnt_q <= cnt_inc;
    end
  end

  assign bus.PSW_SIG   = sig;
  assign bus.PSW_PULSE = pulse;
  assign bus.CPU_EN    = cpu_en_q;
  assign bus.CPU_CLK   = (stretch_q != '0);
  assign bus.MODE      = mode_q;
  assign bus.RATE      = rate_q;
  assign bus.STEP_CNT  = cnt_q;
endmodule
`default_nettype wire
